// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC register and IF/ID pipeline register
//
// Purpose: holds the fetch PC (PC_F), presents it to an asynchronous
// instruction ROM, and captures the fetched word into the IF/ID register.
// Handles stall, flush, branch/jal and jalr redirects with alignment checking.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   imem_addr/imem_rdata  fetch address out, instruction word in (same cycle)
//   stall, flush          hazard controls from the hazard unit
//   pc_src                00/11 sequential, 01 pc_d + imm_ext, 10 jalr_target
//   imm_ext, jalr_target  redirect operands from decode / execute
//   instr_d, pc_d,
//   pc_plus4_d, valid_d   IF/ID register contents
//   misalign_err          one-cycle pulse after a redirect whose target was misaligned

module fetch_stage #(
    parameter int                 D_WIDTH   = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [D_WIDTH-1:0] NOP_INSTR = D_WIDTH'(32'h0000_0013)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic [D_WIDTH-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic [1:0]         pc_src,
    input  logic [D_WIDTH-1:0] imm_ext,
    input  logic [D_WIDTH-1:0] jalr_target,
    output logic [D_WIDTH-1:0] instr_d,
    output logic [D_WIDTH-1:0] pc_d,
    output logic [D_WIDTH-1:0] pc_plus4_d,
    output logic               valid_d,
    output logic               misalign_err
);

    logic [D_WIDTH-1:0] pc_f_q, pc_f_d;
    logic [D_WIDTH-1:0] instr_d_q, instr_d_d;
    logic [D_WIDTH-1:0] pc_d_q, pc_d_d;
    logic [D_WIDTH-1:0] pc_plus4_d_q, pc_plus4_d_d;
    logic               valid_d_q, valid_d_d;
    logic               misalign_err_q, misalign_err_d;

    logic               redirect;
    logic [D_WIDTH-1:0] target_raw;
    logic [D_WIDTH-1:0] pc_plus4_f;

    always_comb begin
        redirect   = (pc_src == 2'b01) || (pc_src == 2'b10);
        pc_plus4_f = pc_f_q + D_WIDTH'(4);
        // Branch target uses the registered decode PC, never a bypassed value.
        // jalr clears bit 0 first, so only bit 1 can flag a jalr misalignment.
        if (pc_src == 2'b01) begin
            target_raw = pc_d_q + imm_ext;
        end else begin
            target_raw = jalr_target & ~D_WIDTH'(1);
        end

        pc_f_d         = pc_f_q;
        instr_d_d      = instr_d_q;
        pc_d_d         = pc_d_q;
        pc_plus4_d_d   = pc_plus4_d_q;
        valid_d_d      = valid_d_q;
        misalign_err_d = 1'b0;

        if (stall) begin
            if (flush) begin
                instr_d_d = NOP_INSTR;
                valid_d_d = 1'b0;
            end
        end else if (redirect) begin
            // The instruction fetched this cycle is wrong-path: always bubble.
            pc_f_d         = {target_raw[D_WIDTH-1:2], 2'b00};
            misalign_err_d = |target_raw[1:0];
            instr_d_d      = NOP_INSTR;
            valid_d_d      = 1'b0;
        end else begin
            pc_f_d = pc_plus4_f;
            if (flush) begin
                instr_d_d = NOP_INSTR;
                valid_d_d = 1'b0;
            end else begin
                instr_d_d    = imem_rdata;
                pc_d_d       = pc_f_q;
                pc_plus4_d_d = pc_plus4_f;
                valid_d_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q         <= RESET_PC;
            instr_d_q      <= NOP_INSTR;
            pc_d_q         <= '0;
            pc_plus4_d_q   <= '0;
            valid_d_q      <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            pc_f_q         <= pc_f_d;
            instr_d_q      <= instr_d_d;
            pc_d_q         <= pc_d_d;
            pc_plus4_d_q   <= pc_plus4_d_d;
            valid_d_q      <= valid_d_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign imem_addr    = pc_f_q;
    assign instr_d      = instr_d_q;
    assign pc_d         = pc_d_q;
    assign pc_plus4_d   = pc_plus4_d_q;
    assign valid_d      = valid_d_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: D_WIDTH, 32, datapath and address width.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter: NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 imem_addr  output  D_WIDTH  current fetch PC (PC_F) to instruction memory; combinational from PC register.
REQ-007 imem_rdata  input  D_WIDTH  instruction word at imem_addr, valid same cycle (asynchronous ROM).
REQ-008 stall  input  1  hold PC_F and IF/ID register.
REQ-009 flush  input  1  replace IF/ID contents with bubble on next edge.
REQ-010 pc_src  input  2  00 sequential, 01 branch/jal (PC_D + imm_ext), 10 jalr (jalr_target), 11 reserved (treated as 00).
REQ-011 imm_ext  input  D_WIDTH  sign-extended immediate of the instruction in decode.
REQ-012 jalr_target  input  D_WIDTH  rs1 + immediate for jalr.
REQ-013 instr_d  output  D_WIDTH  IF/ID instruction; drives the sign-extension unit's instr input.
REQ-014 pc_d  output  D_WIDTH  PC of instr_d.
REQ-015 pc_plus4_d  output  D_WIDTH  pc_d + 4 (link value for jal/jalr).
REQ-016 valid_d  output  1  instr_d is a real fetched instruction (0 = bubble).
REQ-017 misalign_err  output  1  one-cycle pulse: redirect target had bits [1:0] != 00 after jalr bit-0 clear.

Function
REQ-018 Redirect target: pc_src=01 -> pc_d + imm_ext (modulo 2^D_WIDTH); pc_src=10 -> jalr_target with bit 0 cleared.
REQ-019 Redirect target bits [1:0] SHALL be forced to 00 before loading PC_F; misalign_err SHALL pulse high on the following cycle when any forced bit was 1.
REQ-020 Per edge, priority: rst > stall > redirect (pc_src 01/10) > flush > normal.
REQ-021 Normal: PC_F <= PC_F + 4 (wraps 32'hFFFF_FFFC -> 0); IF/ID <= {imem_rdata, PC_F, PC_F+4, valid=1}.
REQ-022 Stall (stall=1, flush=0): PC_F and IF/ID hold; pc_src ignored; misalign_err low.
REQ-023 Stall with flush: PC_F holds; IF/ID becomes bubble.
REQ-024 Redirect (stall=0): PC_F <= target; IF/ID becomes bubble regardless of flush (wrong-path instruction discarded).
REQ-025 Flush only (stall=0, pc_src 00/11): PC_F <= PC_F + 4; IF/ID becomes bubble.
REQ-026 Bubble: instr_d=NOP_INSTR, valid_d=0, pc_d and pc_plus4_d hold previous values.
REQ-027 Redirect SHALL use pc_d as registered at the edge, not a bypassed value.
REQ-028 Fetch-to-decode latency one cycle; redirect penalty exactly one bubble.
REQ-029 imem_addr SHALL equal PC_F at all times, including during stall.

Reset
REQ-030 While rst=1 at an edge: PC_F <= RESET_PC, instr_d <= NOP_INSTR, pc_d <= 0, pc_plus4_d <= 0, valid_d <= 0, misalign_err <= 0; stall, flush, pc_src ignored.
REQ-031 First cycle after rst deasserts: imem_addr=RESET_PC, valid_d=0; next edge loads the first instruction.
REQ-032 Reset asserted mid-stall or coincident with a redirect SHALL discard both.

Verification
REQ-033 Reset then 3 free-running cycles with ROM[0]=0x00500093, ROM[4]=0x00A00113 -> imem_addr 0,4,8; instr_d NOP, 0x00500093 (pc_d=0, pc_plus4_d=4, valid_d=1), 0x00A00113 (pc_d=4).
REQ-034 Branch: pc_d=8, pc_src=01, imm_ext=0xFFFF_FFF8 -> next imem_addr=0, instr_d=NOP, valid_d=0; following edge fetches address 0 with valid_d=1.
REQ-035 jalr: jalr_target=0x0000_0107, pc_src=10 -> imem_addr=0x104, misalign_err pulses one cycle; jalr_target=0x101 -> imem_addr=0x100, no pulse.
REQ-036 stall=1 for 3 cycles at PC_F=0x10 with pc_src=01 -> imem_addr stays 0x10, instr_d/pc_d unchanged, no redirect taken; stall+flush -> valid_d=0, PC_F still 0x10.
REQ-037 PC_F=0xFFFF_FFFC free-running -> next imem_addr=0; rst asserted during stall with pc_src=10 -> imem_addr=RESET_PC, valid_d=0, misalign_err=0.
